// File: rtl/car_pkg.sv
// Shared car-domain definitions: motion FSM state encoding and datapath widths.
package car_pkg;

  localparam int SPEED_W = 8;
  localparam int ODO_W   = 16;

  typedef enum logic [2:0] {
    STOPPED   = 3'd0,
    ACCEL     = 3'd1,
    BRAKE     = 3'd2,
    DOOR_WAIT = 3'd3,
    DOOR_OPEN = 3'd4
  } motion_state_t;

endpackage

// File: rtl/car_motion_unit_prescaler.sv
// Free-running tick generator: pulses tick for one cycle every TICK_DIV clocks.
// Reusable by any car-domain timer that needs a slower update rate.
module tick_prescaler #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int               CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // Count 0..TICK_DIV-1 and wrap; the tick cycle is the last count value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/car_motion_unit.sv
// Plant-side motion model downstream of the car control unit.
// Integrates vehicle speed on a prescaled tick and sequences the door lock.
// Optional feature: define CAR_ODOMETER_EN to add the 16-bit odometer output.
module car_motion_unit
  import car_pkg::*;
#(
  parameter int TICK_DIV   = 10,
  parameter int ACCEL_STEP = 2,
  parameter int BRAKE_STEP = 4,
  parameter int MAX_SPEED  = 200,
  parameter int DOOR_DELAY = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               accelerate_car,
  input  logic               unlock_doors,
  output logic [SPEED_W-1:0] car_speed,
  output logic               moving,
  output logic               doors_unlocked,
  output logic               tick
`ifdef CAR_ODOMETER_EN
  ,
  output logic [ODO_W-1:0]   odometer
`endif
);

  localparam int                 DLY_W      = $clog2(DOOR_DELAY + 1);
  localparam logic [DLY_W-1:0]   DLY_DONE   = DLY_W'(DOOR_DELAY);
  localparam logic [SPEED_W:0]   ACCEL_STEP9 = (SPEED_W + 1)'(ACCEL_STEP);
  localparam logic [SPEED_W:0]   MAX_SPEED9  = (SPEED_W + 1)'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] MAX_SPEED8  = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] BRAKE_STEP8 = SPEED_W'(BRAKE_STEP);

  motion_state_t      state;
  motion_state_t      next_state;
  logic [DLY_W-1:0]   delay_count;
  logic [SPEED_W:0]   accel_sum;
  logic [SPEED_W-1:0] accel_speed;
  logic [SPEED_W-1:0] brake_speed;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Next-state decode; commands are acted on every cycle, independent of tick.
  always_comb begin
    next_state = state;
    case (state)
      STOPPED: begin
        if (accelerate_car) begin
          next_state = ACCEL;
        end else if (unlock_doors) begin
          next_state = DOOR_WAIT;
        end
      end
      ACCEL: begin
        if (!accelerate_car) begin
          next_state = BRAKE;
        end
      end
      BRAKE: begin
        if (accelerate_car) begin
          next_state = ACCEL;
        end else if (car_speed == '0) begin
          next_state = STOPPED;
        end
      end
      DOOR_WAIT: begin
        if (accelerate_car || !unlock_doors) begin
          next_state = STOPPED;
        end else if (delay_count == DLY_DONE) begin
          next_state = DOOR_OPEN;
        end
      end
      DOOR_OPEN: begin
        if (accelerate_car || !unlock_doors) begin
          next_state = STOPPED;
        end
      end
      default: next_state = STOPPED;
    endcase
  end

  // State register; leaving DOOR_OPEN always passes through STOPPED so the lock re-engages first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STOPPED;
    end else begin
      state <= next_state;
    end
  end

  // Settle counter: cleared outside DOOR_WAIT so every unlock attempt waits the full delay,
  // which opens the doors DOOR_DELAY+1 edges after the request edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_count <= '0;
    end else if (state != DOOR_WAIT) begin
      delay_count <= '0;
    end else if (delay_count != DLY_DONE) begin
      delay_count <= delay_count + 1'b1;
    end
  end

  // Candidate speeds: saturating add in one extra bit, and a floor-at-zero subtract.
  always_comb begin
    accel_sum   = {1'b0, car_speed} + ACCEL_STEP9;
    accel_speed = (accel_sum > MAX_SPEED9) ? MAX_SPEED8 : accel_sum[SPEED_W-1:0];
    brake_speed = (car_speed < BRAKE_STEP8) ? '0 : (car_speed - BRAKE_STEP8);
  end

  // Speed integrates only on tick, using the state held before any same-edge transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_speed <= '0;
    end else if (tick) begin
      case (state)
        ACCEL:   car_speed <= accel_speed;
        BRAKE:   car_speed <= brake_speed;
        default: car_speed <= car_speed;
      endcase
    end
  end

`ifdef CAR_ODOMETER_EN
  // Distance accumulates the pre-update speed each tick and wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      odometer <= '0;
    end else if (tick) begin
      odometer <= odometer + ODO_W'(car_speed);
    end
  end
`endif

  assign moving         = (state == ACCEL) || (state == BRAKE);
  assign doors_unlocked = (state == DOOR_OPEN);

endmodule

// File: tb/tb_car_motion_unit.sv
// Directed self-checking bench for car_motion_unit with hand-computed expectations.
// Edge numbering below: e1 is the first rising edge after reset is released.
module tb_car_motion_unit;
  import car_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               accelerate_car;
  logic               unlock_doors;
  logic [SPEED_W-1:0] car_speed;
  logic               moving;
  logic               doors_unlocked;
  logic               tick;
`ifdef CAR_ODOMETER_EN
  logic [ODO_W-1:0]   odometer;
`endif

  int error_count;
  int check_count;

  car_motion_unit #(
    .TICK_DIV   (10),
    .ACCEL_STEP (2),
    .BRAKE_STEP (4),
    .MAX_SPEED  (200),
    .DOOR_DELAY (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .accelerate_car (accelerate_car),
    .unlock_doors   (unlock_doors),
    .car_speed      (car_speed),
    .moving         (moving),
    .doors_unlocked (doors_unlocked),
    .tick           (tick)
`ifdef CAR_ODOMETER_EN
    ,
    .odometer       (odometer)
`endif
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic accel, input logic unlock);
    accelerate_car = accel;
    unlock_doors   = unlock;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves rst_n released 1 ns after an edge, so the next edge is e1.
  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Main directed sequence
  initial begin
    error_count = 0;
    check_count = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);

    #12;
    checkOutput("reset_speed", 32'(car_speed), 32'd0);
    checkOutput("reset_moving", 32'(moving), 32'd0);
    checkOutput("reset_doors", 32'(doors_unlocked), 32'd0);
    checkOutput("reset_tick", 32'(tick), 32'd0);
`ifdef CAR_ODOMETER_EN
    checkOutput("reset_odometer", 32'(odometer), 32'd0);
`endif

    // Asynchronous reset in the middle of acceleration at speed 60
    pulseReset();
    applyStimulus(1'b1, 1'b0);
    stepCycles(300);
    checkOutput("pre_reset_speed", 32'(car_speed), 32'd60);
    checkOutput("pre_reset_moving", 32'(moving), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_speed", 32'(car_speed), 32'd0);
    checkOutput("async_reset_moving", 32'(moving), 32'd0);
    checkOutput("async_reset_doors", 32'(doors_unlocked), 32'd0);
    checkOutput("async_reset_tick", 32'(tick), 32'd0);
    pulseReset();
    stepCycles(3);
    checkOutput("post_reset_moving", 32'(moving), 32'd0);
    checkOutput("post_reset_speed", 32'(car_speed), 32'd0);

    // Acceleration to 100, then saturation at 200
    pulseReset();
    applyStimulus(1'b1, 1'b0);
    stepCycles(499);
    checkOutput("tick_at_e499", 32'(tick), 32'd1);
    checkOutput("speed_at_e499", 32'(car_speed), 32'd98);
    stepCycles(1);
    checkOutput("speed_50_ticks", 32'(car_speed), 32'd100);
    checkOutput("moving_accel", 32'(moving), 32'd1);
    checkOutput("tick_after_wrap", 32'(tick), 32'd0);
    stepCycles(490);
    checkOutput("speed_99_ticks", 32'(car_speed), 32'd198);
    stepCycles(10);
    checkOutput("speed_100_ticks", 32'(car_speed), 32'd200);
    stepCycles(10);
    checkOutput("speed_saturated", 32'(car_speed), 32'd200);
    stepCycles(90);
    checkOutput("speed_110_ticks", 32'(car_speed), 32'd200);
`ifdef CAR_ODOMETER_EN
    checkOutput("odometer_110_ticks", 32'(odometer), 32'd11900);
    stepCycles(4000);
    checkOutput("odometer_wrap", 32'(odometer), 32'd26364);
    checkOutput("speed_after_cruise", 32'(car_speed), 32'd200);
`endif

    // Braking from 10: 6, 2, 0, then STOPPED
    pulseReset();
    applyStimulus(1'b1, 1'b0);
    stepCycles(50);
    checkOutput("brake_start_speed", 32'(car_speed), 32'd10);
    applyStimulus(1'b0, 1'b0);
    stepCycles(9);
    checkOutput("brake_no_early_change", 32'(car_speed), 32'd10);
    checkOutput("brake_moving", 32'(moving), 32'd1);
    stepCycles(1);
    checkOutput("brake_speed_6", 32'(car_speed), 32'd6);
    stepCycles(10);
    checkOutput("brake_speed_2", 32'(car_speed), 32'd2);
    stepCycles(10);
    checkOutput("brake_speed_0", 32'(car_speed), 32'd0);
    checkOutput("brake_moving_at_0", 32'(moving), 32'd1);
    stepCycles(1);
    checkOutput("brake_stopped", 32'(moving), 32'd0);
    stepCycles(9);
    checkOutput("brake_no_wrap", 32'(car_speed), 32'd0);

    // Door unlock after the settle delay, then relock on acceleration request
    pulseReset();
    applyStimulus(1'b0, 1'b1);
    stepCycles(5);
    checkOutput("door_wait_e5", 32'(doors_unlocked), 32'd0);
    stepCycles(1);
    checkOutput("door_open_e6", 32'(doors_unlocked), 32'd1);
    checkOutput("door_open_moving", 32'(moving), 32'd0);
    applyStimulus(1'b1, 1'b1);
    stepCycles(1);
    checkOutput("relock_doors", 32'(doors_unlocked), 32'd0);
    checkOutput("relock_stopped", 32'(moving), 32'd0);
    stepCycles(1);
    checkOutput("relock_then_accel", 32'(moving), 32'd1);
    checkOutput("relock_accel_doors", 32'(doors_unlocked), 32'd0);

    // Unlock request dropped early, then a full fresh delay is required
    pulseReset();
    applyStimulus(1'b0, 1'b1);
    stepCycles(3);
    applyStimulus(1'b0, 1'b0);
    stepCycles(3);
    checkOutput("abort_doors_e6", 32'(doors_unlocked), 32'd0);
    stepCycles(2);
    checkOutput("abort_doors_e8", 32'(doors_unlocked), 32'd0);
    checkOutput("abort_moving_e8", 32'(moving), 32'd0);
    applyStimulus(1'b0, 1'b1);
    stepCycles(5);
    checkOutput("retry_doors_e13", 32'(doors_unlocked), 32'd0);
    stepCycles(1);
    checkOutput("retry_doors_e14", 32'(doors_unlocked), 32'd1);
    applyStimulus(1'b0, 1'b0);
    stepCycles(1);
    checkOutput("unlock_drop_relock", 32'(doors_unlocked), 32'd0);

    // Both commands together: acceleration wins, unlock ignored while moving
    pulseReset();
    applyStimulus(1'b1, 1'b1);
    stepCycles(1);
    checkOutput("both_moving", 32'(moving), 32'd1);
    checkOutput("both_doors", 32'(doors_unlocked), 32'd0);
    stepCycles(9);
    checkOutput("both_speed_e10", 32'(car_speed), 32'd2);
    stepCycles(10);
    checkOutput("both_speed_e20", 32'(car_speed), 32'd4);
    checkOutput("both_doors_e20", 32'(doors_unlocked), 32'd0);
    applyStimulus(1'b0, 1'b1);
    stepCycles(10);
    checkOutput("brake_unlock_speed", 32'(car_speed), 32'd0);
    checkOutput("brake_unlock_doors", 32'(doors_unlocked), 32'd0);
    stepCycles(1);
    checkOutput("brake_unlock_stopped", 32'(moving), 32'd0);
    stepCycles(5);
    checkOutput("late_unlock_e36", 32'(doors_unlocked), 32'd0);
    stepCycles(1);
    checkOutput("late_unlock_e37", 32'(doors_unlocked), 32'd1);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
